// File: rtl/bst_store.sv
// bst_store: binary-search-tree key store, one node compared per clock.
// Define BST_MULT_EN to add per-node occurrence counters and rsp_mult.
module bst_store #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 7,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic              rsp_full,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [IDX_W-1:0]  rsp_level,
    output logic [IDX_W-1:0]  count,
    output logic              empty,
    output logic              full
`ifdef BST_MULT_EN
    ,
    output logic [3:0]        rsp_mult
`endif
);
    typedef enum logic [1:0] {IDLE, WALK, LINK, RESP} state_t;

    localparam logic [IDX_W-1:0] NIL  = '1;
    localparam logic [IDX_W-1:0] ONE  = 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] CAP  = IDX_W'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] keys  [DEPTH];
    logic [IDX_W-1:0]  left  [DEPTH];
    logic [IDX_W-1:0]  right [DEPTH];
    logic [IDX_W-1:0]  cur;
    logic [IDX_W-1:0]  level;
    logic [IDX_W-1:0]  child;
    logic [IDX_W-1:0]  next_level;
    logic [DATA_W-1:0] key;
    logic              op;
    logic              go_left;
    logic              link_left;
    logic              hit;
    logic              stop;

    assign cmd_ready  = (state == IDLE) && !clear;
    assign hit        = (key == keys[cur]);
    assign go_left    = (key < keys[cur]);
    assign child      = go_left ? left[cur] : right[cur];
    assign next_level = (level == LAST) ? level : level + ONE;
    // Hitting the last legal level ends the walk even if a child exists.
    assign stop       = (child == NIL) || (level == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            cur       <= '0;
            level     <= '0;
            key       <= '0;
            op        <= 1'b0;
            link_left <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_found <= 1'b0;
            rsp_full  <= 1'b0;
            rsp_idx   <= '0;
            rsp_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                left[i]  <= NIL;
                right[i] <= NIL;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        count <= '0;
                        empty <= 1'b1;
                        full  <= 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            left[i]  <= NIL;
                            right[i] <= NIL;
                        end
                    end else if (cmd_valid) begin
                        op    <= cmd_op;
                        key   <= cmd_key;
                        cur   <= '0;
                        level <= '0;
                        if (!empty) begin
                            state <= WALK;
                        end else if (cmd_op) begin
                            state <= LINK;
                        end else begin
                            rsp_found <= 1'b0;
                            rsp_full  <= 1'b0;
                            rsp_idx   <= NIL;
                            rsp_level <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WALK: begin
                    if (hit) begin
                        rsp_found <= 1'b1;
                        rsp_full  <= 1'b0;
                        rsp_idx   <= cur;
                        rsp_level <= level;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (stop) begin
                        level <= next_level;
                        if (op && child == NIL && !full) begin
                            link_left <= go_left;
                            state     <= LINK;
                        end else begin
                            rsp_found <= 1'b0;
                            rsp_full  <= op && full;
                            rsp_idx   <= NIL;
                            rsp_level <= next_level;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end else begin
                        cur   <= child;
                        level <= next_level;
                    end
                end
                LINK: begin
                    left[count]  <= NIL;
                    right[count] <= NIL;
                    if (count != '0) begin
                        if (link_left) left[cur] <= count;
                        else           right[cur] <= count;
                    end
                    count     <= count + ONE;
                    empty     <= 1'b0;
                    full      <= (count + ONE == CAP);
                    rsp_found <= 1'b0;
                    rsp_full  <= 1'b0;
                    rsp_idx   <= count;
                    rsp_level <= level;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    // Key storage needs no reset: a node is only read once linked.
    always_ff @(posedge clk) begin
        if (state == LINK) keys[count] <= key;
    end

`ifdef BST_MULT_EN
    logic [3:0] mult [DEPTH];
    logic [3:0] mult_inc;

    assign mult_inc = (mult[cur] == 4'hf) ? 4'hf : mult[cur] + 4'h1;

    always_ff @(posedge clk) begin
        if (state == LINK)
            mult[count] <= 4'h1;
        else if (state == WALK && hit && op)
            mult[cur] <= mult_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_mult <= '0;
        else if (state == LINK)
            rsp_mult <= 4'h1;
        else if (state == WALK && hit)
            rsp_mult <= op ? mult_inc : mult[cur];
        else if (state == WALK && stop)
            rsp_mult <= '0;
        else if (state == IDLE && cmd_ready && cmd_valid)
            rsp_mult <= '0;
    end
`endif

endmodule
